// File: rtl/tdc_counter_avg.sv
// Counter-based time-to-digital converter for the digital PLL loop.
// Measures the signed cycle distance between a reference and a feedback
// event pulse, optionally averages 2^k measurements, and presents either a
// saturated linear code or a bang-bang sign. Positive output = fb lags ref.
module tdc_counter_avg #(
  parameter int NBIT        = 6,
  parameter int CNT_W       = 10,
  parameter int TMO         = 511,
  parameter int AVG_LOG_MAX = 3
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               en,
  input  logic                               ref_ev,
  input  logic                               fb_ev,
  input  logic                               bb_mode,
  input  logic [$clog2(AVG_LOG_MAX+1)-1:0]   avg_log,
  output logic signed [NBIT-1:0]             out,
  output logic                               out_valid,
  output logic                               sat,
  output logic                               timeout
);

  localparam int KW     = $clog2(AVG_LOG_MAX + 1);
  localparam int ACC_W  = CNT_W + AVG_LOG_MAX + 1;
  localparam int SCNT_W = AVG_LOG_MAX + 1;

  localparam int OUT_MAX_I = (1 << (NBIT - 1)) - 1;
  localparam int OUT_MIN_I = -(1 << (NBIT - 1));
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(OUT_MAX_I);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(OUT_MIN_I);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FB  = 2'd1,
    WAIT_REF = 2'd2
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_next;
  logic signed [CNT_W:0]     raw;
  logic                      done;
  logic                      tmo_hit;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   raw_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   avg;
  logic [SCNT_W-1:0]         scnt;
  logic [SCNT_W-1:0]         scnt_inc;
  logic [SCNT_W-1:0]         win_len;
  logic [KW-1:0]             k_lat;
  logic [KW-1:0]             k_in;
  logic [KW-1:0]             k_eff;
  logic                      win_done;

  logic signed [NBIT-1:0]    out_next;
  logic                      sat_next;

  // Measurement state and interval counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Event handling: closing event wins over a restart, restart wins over counting.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    done       = 1'b0;
    tmo_hit    = 1'b0;
    raw        = '0;
    if (!en) begin
      next_state = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_ev && fb_ev) begin
            done     = 1'b1;
            raw      = '0;
            cnt_next = '0;
          end else if (ref_ev) begin
            next_state = WAIT_FB;
            cnt_next   = CNT_W'(1);
          end else if (fb_ev) begin
            next_state = WAIT_REF;
            cnt_next   = CNT_W'(1);
          end
        end
        WAIT_FB: begin
          if (fb_ev) begin
            done       = 1'b1;
            raw        = $signed({1'b0, cnt});
            next_state = IDLE;
            cnt_next   = '0;
          end else if (ref_ev) begin
            cnt_next = CNT_W'(1);
          end else if (cnt >= CNT_W'(TMO)) begin
            tmo_hit    = 1'b1;
            next_state = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        WAIT_REF: begin
          if (ref_ev) begin
            done       = 1'b1;
            raw        = -$signed({1'b0, cnt});
            next_state = IDLE;
            cnt_next   = '0;
          end else if (fb_ev) begin
            cnt_next = CNT_W'(1);
          end else if (cnt >= CNT_W'(TMO)) begin
            tmo_hit    = 1'b1;
            next_state = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          next_state = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Averaging window: k is clamped, and frozen at the first sample of a window.
  always_comb begin
    k_in = avg_log;
    if ({1'b0, avg_log} > (KW+1)'(AVG_LOG_MAX)) begin
      k_in = KW'(AVG_LOG_MAX);
    end
    k_eff    = (scnt == '0) ? k_in : k_lat;
    win_len  = SCNT_W'(1) << k_eff;
    scnt_inc = scnt + SCNT_W'(1);
    win_done = done && (scnt_inc == win_len);
    raw_ext  = {{(ACC_W-CNT_W-1){raw[CNT_W]}}, raw};
    sum      = acc + raw_ext;
    avg      = sum >>> k_eff;
  end

  // Output code formatting: bang-bang sign or saturated linear value.
  always_comb begin
    out_next = out;
    sat_next = sat;
    if (bb_mode) begin
      sat_next = 1'b0;
      if (avg[ACC_W-1]) begin
        out_next = '1;
      end else if (avg != '0) begin
        out_next = {{(NBIT-1){1'b0}}, 1'b1};
      end else begin
        out_next = '0;
      end
    end else if (avg > OUT_MAX) begin
      out_next = OUT_MAX[NBIT-1:0];
      sat_next = 1'b1;
    end else if (avg < OUT_MIN) begin
      out_next = OUT_MIN[NBIT-1:0];
      sat_next = 1'b1;
    end else begin
      out_next = avg[NBIT-1:0];
      sat_next = 1'b0;
    end
  end

  // Accumulator, sample count and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      scnt      <= '0;
      k_lat     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      timeout   <= 1'b0;
    end else if (!en) begin
      acc       <= '0;
      scnt      <= '0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      out_valid <= win_done;
      timeout   <= tmo_hit;
      if (done) begin
        if (scnt == '0) begin
          k_lat <= k_in;
        end
        if (win_done) begin
          acc  <= '0;
          scnt <= '0;
          out  <= out_next;
          sat  <= sat_next;
        end else begin
          acc  <= sum;
          scnt <= scnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_counter_avg.sv
// Scoreboard bench for tdc_counter_avg: a timestamp-based reference model
// predicts strobes and codes; an independent monitor checks the DUT outputs.
module tb_tdc_counter_avg;

  localparam int NBIT        = 6;
  localparam int CNT_W       = 10;
  localparam int TMO         = 511;
  localparam int AVG_LOG_MAX = 3;
  localparam int KW          = $clog2(AVG_LOG_MAX + 1);

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   en = 1'b0;
  logic                   refEv = 1'b0;
  logic                   fbEv = 1'b0;
  logic                   bbMode = 1'b0;
  logic [KW-1:0]          avgLog = '0;
  logic signed [NBIT-1:0] outCode;
  logic                   outValid;
  logic                   satFlag;
  logic                   timeoutFlag;

  tdc_counter_avg #(
    .NBIT(NBIT), .CNT_W(CNT_W), .TMO(TMO), .AVG_LOG_MAX(AVG_LOG_MAX)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .ref_ev(refEv), .fb_ev(fbEv),
    .bb_mode(bbMode), .avg_log(avgLog), .out(outCode), .out_valid(outValid),
    .sat(satFlag), .timeout(timeoutFlag)
  );

  // Free-running sampling clock.
  always #5 clk = ~clk;

  // Count of active edges, used to timestamp events and strobes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
    bit sat;
  } exp_t;

  exp_t expQ[$];
  int   tmoQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   heldOut = 0;
  bit   heldSat = 1'b0;

  int   pendKind = 0;
  int   pendT = 0;
  int   winQ[$];
  int   winK = 0;
  int   curK = 0;
  bit   curBb = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int floorDiv(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  // A finished measurement joins the current window; a full window yields a code.
  function automatic void modelSample(input int raw, input int t, input int kReq, input bit bb);
    int   sum;
    int   avg;
    exp_t e;
    if (winQ.size() == 0) winK = (kReq > AVG_LOG_MAX) ? AVG_LOG_MAX : kReq;
    winQ.push_back(raw);
    if (winQ.size() == (1 << winK)) begin
      sum = 0;
      foreach (winQ[i]) sum += winQ[i];
      avg = floorDiv(sum, 1 << winK);
      e.cyc = t;
      if (bb) begin
        e.val = (avg > 0) ? 1 : ((avg < 0) ? -1 : 0);
        e.sat = 1'b0;
      end else if (avg > (1 << (NBIT - 1)) - 1) begin
        e.val = (1 << (NBIT - 1)) - 1;
        e.sat = 1'b1;
      end else if (avg < -(1 << (NBIT - 1))) begin
        e.val = -(1 << (NBIT - 1));
        e.sat = 1'b1;
      end else begin
        e.val = avg;
        e.sat = 1'b0;
      end
      expQ.push_back(e);
      winQ.delete();
    end
  endfunction

  // Reference model: timestamps of the pending opening event, no counter.
  function automatic void modelStep(input int t, input bit e, input bit r, input bit f,
                                    input int k, input bit bb);
    if (!e) begin
      pendKind = 0;
      winQ.delete();
      return;
    end
    case (pendKind)
      0: begin
        if (r && f) modelSample(0, t, k, bb);
        else if (r) begin pendKind = 1; pendT = t; end
        else if (f) begin pendKind = 2; pendT = t; end
      end
      1: begin
        if (f) begin modelSample(t - pendT, t, k, bb); pendKind = 0; end
        else if (r) pendT = t;
        else if (t + 1 - pendT > TMO) begin tmoQ.push_back(t); pendKind = 0; end
      end
      default: begin
        if (r) begin modelSample(pendT - t, t, k, bb); pendKind = 0; end
        else if (f) pendT = t;
        else if (t + 1 - pendT > TMO) begin tmoQ.push_back(t); pendKind = 0; end
      end
    endcase
  endfunction

  task automatic applyStimulus(input bit e, input bit r, input bit f, input int k, input bit bb);
    @(negedge clk);
    en     = e;
    refEv  = r;
    fbEv   = f;
    avgLog = k[KW-1:0];
    bbMode = bb;
    modelStep(cyc + 1, e, r, f, k, bb);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, curK, curBb);
  endtask

  task automatic runGap(input int gap);
    if (gap == 0) begin
      applyStimulus(1'b1, 1'b1, 1'b1, curK, curBb);
    end else if (gap > 0) begin
      applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
      idle(gap - 1);
      applyStimulus(1'b1, 1'b0, 1'b1, curK, curBb);
    end else begin
      applyStimulus(1'b1, 1'b0, 1'b1, curK, curBb);
      idle(-gap - 1);
      applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
    end
    idle(2);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rstn  = 1'b0;
    en    = 1'b0;
    refEv = 1'b0;
    fbEv  = 1'b0;
    pendKind = 0;
    winQ.delete();
    expQ.delete();
    tmoQ.delete();
    heldOut = 0;
    heldSat = 1'b0;
    #1;
    checkOutput("rst_out", int'(outCode), 0);
    checkOutput("rst_valid", int'(outValid), 0);
    checkOutput("rst_sat", int'(satFlag), 0);
    checkOutput("rst_timeout", int'(timeoutFlag), 0);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  // Monitor: pops expected strobes as the DUT presents them, checks holds otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        if (outValid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("valid_cycle", cyc, e.cyc);
            checkOutput("out", int'(outCode), e.val);
            checkOutput("sat", int'(satFlag), int'(e.sat));
            heldOut = e.val;
            heldSat = e.sat;
          end
        end else begin
          while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            checkOutput("missing_valid", 0, e.cyc);
          end
          checkOutput("hold_out", int'(outCode), heldOut);
          checkOutput("hold_sat", int'(satFlag), int'(heldSat));
        end
        if (timeoutFlag) begin
          if (tmoQ.size() == 0) checkOutput("unexpected_timeout", 1, 0);
          else checkOutput("timeout_cycle", cyc, tmoQ.pop_front());
        end else begin
          while (tmoQ.size() > 0 && tmoQ[0] <= cyc) begin
            checkOutput("missing_timeout", 0, tmoQ.pop_front());
          end
        end
      end
    end
  end

  // Directed scenarios followed by dense and sparse random traffic.
  initial begin
    bit e;
    bit r;
    bit f;
    repeat (3) @(negedge clk);
    checkOutput("init_out", int'(outCode), 0);
    checkOutput("init_valid", int'(outValid), 0);
    checkOutput("init_sat", int'(satFlag), 0);
    checkOutput("init_timeout", int'(timeoutFlag), 0);
    #2;
    rstn = 1'b1;

    curK = 0;
    curBb = 1'b0;
    idle(3);
    runGap(3);
    runGap(-5);
    runGap(0);
    runGap(40);
    runGap(-40);
    runGap(2);

    curK = 2;
    runGap(3);
    runGap(4);
    runGap(-1);
    runGap(1);
    curBb = 1'b1;
    runGap(-1);
    runGap(-1);
    runGap(0);
    runGap(0);

    curK = 0;
    curBb = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
    idle(TMO + 5);
    runGap(2);

    applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b1, curK, curBb);
    idle(3);

    applyStimulus(1'b1, 1'b1, 1'b0, curK, curBb);
    idle(3);
    doReset();
    idle(6);
    runGap(7);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) curK = $urandom_range(0, AVG_LOG_MAX);
      if ($urandom_range(0, 29) == 0) curBb = $urandom_range(0, 1) != 0;
      e = $urandom_range(0, 49) != 0;
      r = $urandom_range(0, 5) == 0;
      f = $urandom_range(0, 5) == 0;
      applyStimulus(e, r, f, curK, curBb);
    end

    curK = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 999) == 0) curBb = $urandom_range(0, 1) != 0;
      r = $urandom_range(0, 399) == 0;
      f = $urandom_range(0, 399) == 0;
      applyStimulus(1'b1, r, f, curK, curBb);
    end

    idle(6);
    checkOutput("drain_valid", expQ.size(), 0);
    checkOutput("drain_timeout", tmoQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
